// File: rtl/tt_um_jleugeri_ttt_scheduler_if.sv
// Bus between the scheduler, the chip-side token/config sources and the shared core.
// The slave side is the scheduler; the master side drives tokens, config and core results.
interface tt_um_jleugeri_ttt_scheduler_if #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CH_BITS       = 2,
  parameter int unsigned TOKENS_BITS   = 4,
  parameter int unsigned DURATION_BITS = 4
) ();
  // Token increments
  logic                     in_valid;
  logic [CH_BITS-1:0]       in_channel;
  logic [TOKENS_BITS-1:0]   in_good;
  logic [TOKENS_BITS-1:0]   in_bad;
  logic                     in_ready;
  // Sweep request and configuration
  logic                     tick;
  logic                     cfg_we;
  logic [CH_BITS-1:0]       cfg_channel;
  logic [TOKENS_BITS-1:0]   cfg_good_thr;
  logic [TOKENS_BITS-1:0]   cfg_bad_thr;
  logic [DURATION_BITS-1:0] cfg_duration;
  // Core issue
  logic                     core_valid;
  logic [CH_BITS-1:0]       core_channel;
  logic [TOKENS_BITS-1:0]   core_good;
  logic [TOKENS_BITS-1:0]   core_bad;
  logic [TOKENS_BITS-1:0]   core_good_thr;
  logic [TOKENS_BITS-1:0]   core_bad_thr;
  logic [DURATION_BITS-1:0] core_duration;
  logic                     core_tick;
  // Core result
  logic                     core_done;
  logic                     core_token_start;
  logic                     core_token_end;
  // Status
  logic [NUM_CHANNELS-1:0]  active;
  logic                     busy;

  modport slave (
    input  in_valid, in_channel, in_good, in_bad, tick,
    input  cfg_we, cfg_channel, cfg_good_thr, cfg_bad_thr, cfg_duration,
    input  core_done, core_token_start, core_token_end,
    output in_ready, core_valid, core_channel, core_good, core_bad,
    output core_good_thr, core_bad_thr, core_duration, core_tick, active, busy
  );

  modport master (
    output in_valid, in_channel, in_good, in_bad, tick,
    output cfg_we, cfg_channel, cfg_good_thr, cfg_bad_thr, cfg_duration,
    output core_done, core_token_start, core_token_end,
    input  in_ready, core_valid, core_channel, core_good, core_bad,
    input  core_good_thr, core_bad_thr, core_duration, core_tick, active, busy
  );
endinterface

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Round-robin scheduler time-sharing one processor core among NUM_CHANNELS virtual
// processors. Pending tokens and per-channel config are snapshotted into the core_*
// registers on issue; core results maintain a per-channel active flag.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CH_BITS       = 2,
  parameter int unsigned TOKENS_BITS   = 4,
  parameter int unsigned DURATION_BITS = 4
) (
  input logic clk,
  input logic reset,
  tt_um_jleugeri_ttt_scheduler_if.slave bus_io
);
  localparam logic [TOKENS_BITS-1:0] TokMax  = '1;
  localparam logic [CH_BITS-1:0]     LastCh  = CH_BITS'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [TOKENS_BITS-1:0]   pend_good_q [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   pend_good_d [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   pend_bad_q  [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   pend_bad_d  [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   cfg_good_thr_q [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   cfg_good_thr_d [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   cfg_bad_thr_q  [NUM_CHANNELS];
  logic [TOKENS_BITS-1:0]   cfg_bad_thr_d  [NUM_CHANNELS];
  logic [DURATION_BITS-1:0] cfg_duration_q [NUM_CHANNELS];
  logic [DURATION_BITS-1:0] cfg_duration_d [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]  active_q, active_d;
  logic                     sweep_q, sweep_d;
  logic [CH_BITS-1:0]       sweep_idx_q, sweep_idx_d;
  logic [CH_BITS-1:0]       ptr_q, ptr_d;
  logic                     busy_q, busy_d;

  logic                     core_valid_q, core_valid_d;
  logic [CH_BITS-1:0]       core_channel_q, core_channel_d;
  logic [TOKENS_BITS-1:0]   core_good_q, core_good_d;
  logic [TOKENS_BITS-1:0]   core_bad_q, core_bad_d;
  logic [TOKENS_BITS-1:0]   core_good_thr_q, core_good_thr_d;
  logic [TOKENS_BITS-1:0]   core_bad_thr_q, core_bad_thr_d;
  logic [DURATION_BITS-1:0] core_duration_q, core_duration_d;
  logic                     core_tick_q, core_tick_d;

  logic                     sel_valid;
  logic                     sel_sweep;
  logic [CH_BITS-1:0]       sel_ch;
  logic [CH_BITS-1:0]       rr_idx;
  logic                     hit_in;
  logic                     hit_cfg;

  function automatic logic [TOKENS_BITS-1:0] sat_add(input logic [TOKENS_BITS-1:0] a,
                                                     input logic [TOKENS_BITS-1:0] b);
    logic [TOKENS_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TOKENS_BITS] ? TokMax : s[TOKENS_BITS-1:0];
  endfunction

  // Channel selection in IDLE: sweep first, else first non-empty channel after the pointer
  always_comb begin
    sel_valid = 1'b0;
    sel_sweep = 1'b0;
    sel_ch    = '0;
    rr_idx    = '0;
    if (state_q == StIdle) begin
      if (sweep_q) begin
        sel_valid = 1'b1;
        sel_sweep = 1'b1;
        sel_ch    = sweep_idx_q;
      end else begin
        // k = NUM_CHANNELS wraps to the pointer itself, so it is checked last
        for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
          rr_idx = ptr_q + CH_BITS'(k);
          if (!sel_valid && (pend_good_q[rr_idx] != '0 || pend_bad_q[rr_idx] != '0)) begin
            sel_valid = 1'b1;
            sel_ch    = rr_idx;
          end
        end
      end
    end
  end

  // Pending accumulation and config writes; a selected channel restarts from this cycle's
  // increment so nothing is lost or counted twice
  always_comb begin
    hit_in  = 1'b0;
    hit_cfg = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      hit_in  = bus_io.in_valid && (bus_io.in_channel == CH_BITS'(i));
      hit_cfg = bus_io.cfg_we && (bus_io.cfg_channel == CH_BITS'(i));
      if (sel_valid && sel_ch == CH_BITS'(i)) begin
        pend_good_d[i] = hit_in ? bus_io.in_good : '0;
        pend_bad_d[i]  = hit_in ? bus_io.in_bad : '0;
      end else begin
        pend_good_d[i] = sat_add(pend_good_q[i], hit_in ? bus_io.in_good : '0);
        pend_bad_d[i]  = sat_add(pend_bad_q[i], hit_in ? bus_io.in_bad : '0);
      end
      cfg_good_thr_d[i] = hit_cfg ? bus_io.cfg_good_thr : cfg_good_thr_q[i];
      cfg_bad_thr_d[i]  = hit_cfg ? bus_io.cfg_bad_thr : cfg_bad_thr_q[i];
      cfg_duration_d[i] = hit_cfg ? bus_io.cfg_duration : cfg_duration_q[i];
    end
  end

  // FSM next state, issue snapshot, sweep bookkeeping and active-flag update
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q | bus_io.tick;
    sweep_idx_d     = sweep_idx_q;
    ptr_d           = ptr_q;
    active_d        = active_q;
    core_valid_d    = 1'b0;
    core_channel_d  = core_channel_q;
    core_good_d     = core_good_q;
    core_bad_d      = core_bad_q;
    core_good_thr_d = core_good_thr_q;
    core_bad_thr_d  = core_bad_thr_q;
    core_duration_d = core_duration_q;
    core_tick_d     = core_tick_q;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d         = StIssue;
          core_valid_d    = 1'b1;
          core_channel_d  = sel_ch;
          core_good_d     = pend_good_q[sel_ch];
          core_bad_d      = pend_bad_q[sel_ch];
          core_good_thr_d = cfg_good_thr_q[sel_ch];
          core_bad_thr_d  = cfg_bad_thr_q[sel_ch];
          core_duration_d = cfg_duration_q[sel_ch];
          core_tick_d     = sel_sweep;
          ptr_d           = sel_ch;
          if (sel_sweep) begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            // A tick landing on the final sweep issue is merged into this sweep
            if (sweep_idx_q == LastCh) begin
              sweep_d = 1'b0;
            end
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus_io.core_done) begin
          state_d = StIdle;
          if (bus_io.core_token_end) begin
            active_d[core_channel_q] = 1'b0;
          end else if (bus_io.core_token_start) begin
            active_d[core_channel_q] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      sweep_q         <= 1'b0;
      sweep_idx_q     <= '0;
      ptr_q           <= LastCh;
      active_q        <= '0;
      busy_q          <= 1'b0;
      core_valid_q    <= 1'b0;
      core_channel_q  <= '0;
      core_good_q     <= '0;
      core_bad_q      <= '0;
      core_good_thr_q <= '1;
      core_bad_thr_q  <= '1;
      core_duration_q <= '0;
      core_tick_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        pend_good_q[i]    <= '0;
        pend_bad_q[i]     <= '0;
        cfg_good_thr_q[i] <= '1;
        cfg_bad_thr_q[i]  <= '1;
        cfg_duration_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      sweep_q         <= sweep_d;
      sweep_idx_q     <= sweep_idx_d;
      ptr_q           <= ptr_d;
      active_q        <= active_d;
      busy_q          <= busy_d;
      core_valid_q    <= core_valid_d;
      core_channel_q  <= core_channel_d;
      core_good_q     <= core_good_d;
      core_bad_q      <= core_bad_d;
      core_good_thr_q <= core_good_thr_d;
      core_bad_thr_q  <= core_bad_thr_d;
      core_duration_q <= core_duration_d;
      core_tick_q     <= core_tick_d;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        pend_good_q[i]    <= pend_good_d[i];
        pend_bad_q[i]     <= pend_bad_d[i];
        cfg_good_thr_q[i] <= cfg_good_thr_d[i];
        cfg_bad_thr_q[i]  <= cfg_bad_thr_d[i];
        cfg_duration_q[i] <= cfg_duration_d[i];
      end
    end
  end

  // The scheduler never back-pressures increments
  assign bus_io.in_ready      = ~reset;
  assign bus_io.core_valid    = core_valid_q;
  assign bus_io.core_channel  = core_channel_q;
  assign bus_io.core_good     = core_good_q;
  assign bus_io.core_bad      = core_bad_q;
  assign bus_io.core_good_thr = core_good_thr_q;
  assign bus_io.core_bad_thr  = core_bad_thr_q;
  assign bus_io.core_duration = core_duration_q;
  assign bus_io.core_tick     = core_tick_q;
  assign bus_io.active        = active_q;
  assign bus_io.busy          = busy_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Scoreboard bench: the driver predicts issue transactions from a channel-level model and
// queues them; a monitor checks every core_valid against the queue; a core responder
// returns results and checks the active flags.
module tb_tt_um_jleugeri_ttt_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tt_um_jleugeri_ttt_scheduler_if #(
    .NUM_CHANNELS(4), .CH_BITS(2), .TOKENS_BITS(4), .DURATION_BITS(4)
  ) ifc ();

  tt_um_jleugeri_ttt_scheduler #(
    .NUM_CHANNELS(4), .CH_BITS(2), .TOKENS_BITS(4), .DURATION_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(ifc)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] gt;
    logic [3:0] bt;
    logic [3:0] d;
    logic       tk;
  } issue_t;

  issue_t exp_q[$];
  issue_t mon_act, mon_exp;
  int checks = 0;
  int errors = 0;
  int n_issues = 0;
  int cur_ch = 0;
  bit hold = 1'b0;
  bit flush = 1'b0;
  bit se_mode = 1'b0;
  bit se_start_fix = 1'b0;
  bit se_end_fix = 1'b0;

  // Channel-level model
  int pend_g[N], pend_b[N], thr_g[N], thr_b[N], dur[N];
  int ptr;
  logic [N-1:0] act_m;

  function automatic int sat(input int a, input int b);
    return (a + b > 15) ? 15 : a + b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pend_g[i] = 0; pend_b[i] = 0; thr_g[i] = 15; thr_b[i] = 15; dur[i] = 0;
    end
    ptr = N - 1;
    act_m = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.in_valid = 1'b0; ifc.in_channel = '0; ifc.in_good = '0; ifc.in_bad = '0;
    ifc.tick = 1'b0; ifc.cfg_we = 1'b0; ifc.cfg_channel = '0;
    ifc.cfg_good_thr = '0; ifc.cfg_bad_thr = '0; ifc.cfg_duration = '0;
  endtask

  task automatic drive_inc(input int ch, input int g, input int b);
    ifc.in_valid = 1'b1; ifc.in_channel = 2'(ch); ifc.in_good = 4'(g); ifc.in_bad = 4'(b);
    pend_g[ch] = sat(pend_g[ch], g);
    pend_b[ch] = sat(pend_b[ch], b);
  endtask

  task automatic drive_cfg(input int ch, input int gt, input int bt, input int d);
    ifc.cfg_we = 1'b1; ifc.cfg_channel = 2'(ch);
    ifc.cfg_good_thr = 4'(gt); ifc.cfg_bad_thr = 4'(bt); ifc.cfg_duration = 4'(d);
    thr_g[ch] = gt; thr_b[ch] = bt; dur[ch] = d;
  endtask

  // Expected issue carries the channel's tokens and its config as known right now
  task automatic push_issue(input int c, input int g, input int b, input bit tk);
    issue_t e;
    e = {2'(c), 4'(g), 4'(b), 4'(thr_g[c]), 4'(thr_b[c]), 4'(dur[c]), tk};
    exp_q.push_back(e);
    pend_g[c] = 0;
    pend_b[c] = 0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (guard < 300 && !(exp_q.size() == 0 && ifc.busy === 1'b0)) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d outstanding issues, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_valid"}, ifc.core_valid, 0);
    check({tag, "_core_channel"}, ifc.core_channel, 0);
    check({tag, "_core_good"}, ifc.core_good, 0);
    check({tag, "_core_bad"}, ifc.core_bad, 0);
    check({tag, "_core_good_thr"}, ifc.core_good_thr, 15);
    check({tag, "_core_bad_thr"}, ifc.core_bad_thr, 15);
    check({tag, "_core_duration"}, ifc.core_duration, 0);
    check({tag, "_core_tick"}, ifc.core_tick, 0);
    check({tag, "_active"}, ifc.active, 0);
    check({tag, "_busy"}, ifc.busy, 0);
    check({tag, "_in_ready"}, ifc.in_ready, 0);
  endtask

  // One episode: an increment to c0 starts an issue held in WAIT while more stimulus
  // arrives; then the core is released and the predicted drain order is queued.
  // mode: 0 quiet, 1 random, 2 saturation on ch1, 3 one increment per channel, 4 two ticks
  task automatic run_segment(input int c0, input int g0, input int b0, input bit collide,
                             input int mode, input int nwait, input bit tick_mid);
    int p0, c, base, guard;
    bit tick_seen;
    wait_idle();
    hold = 1'b1;
    idle_inputs();
    drive_inc(c0, g0, b0);
    step();
    push_issue(c0, pend_g[c0], pend_b[c0], 1'b0);
    ptr = c0;
    idle_inputs();
    // Selection cycle of c0: same-cycle increment/config must only affect the next issue
    if (collide) begin
      drive_inc(c0, $urandom_range(1, 15), $urandom_range(0, 15));
      drive_cfg(c0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    step();
    idle_inputs();
    step();
    tick_seen = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      idle_inputs();
      case (mode)
        1: begin
          if ($urandom_range(0, 1) == 1)
            drive_inc($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0)
            drive_cfg($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15));
          if ($urandom_range(0, 7) == 0) begin
            ifc.tick = 1'b1;
            tick_seen = 1'b1;
          end
        end
        2: drive_inc(1, 4, 0);
        3: drive_inc(i % N, $urandom_range(1, 15), 0);
        4: if (i == 0 || i == 2) begin
          ifc.tick = 1'b1;
          tick_seen = 1'b1;
        end
        default: ;
      endcase
      step();
    end
    idle_inputs();
    if (tick_seen) begin
      for (int k = 0; k < N; k++) push_issue(k, pend_g[k], pend_b[k], 1'b1);
      ptr = N - 1;
    end
    p0 = ptr;
    for (int k = 1; k <= N; k++) begin
      c = (p0 + k) % N;
      if (pend_g[c] != 0 || pend_b[c] != 0) begin
        push_issue(c, pend_g[c], pend_b[c], 1'b0);
        ptr = c;
      end
    end
    base = n_issues;
    hold = 1'b0;
    // A tick during a running sweep must not add another sweep
    if (tick_mid && tick_seen) begin
      guard = 0;
      while (n_issues == base && guard < 100) begin
        step();
        guard++;
      end
      ifc.tick = 1'b1;
      step();
      ifc.tick = 1'b0;
    end
    wait_idle();
  endtask

  task automatic reset_mid_wait();
    int c, base;
    wait_idle();
    hold = 1'b1;
    c = $urandom_range(0, N - 1);
    idle_inputs();
    drive_inc(c, $urandom_range(1, 15), 0);
    step();
    push_issue(c, pend_g[c], pend_b[c], 1'b0);
    idle_inputs();
    step();
    step();
    drive_inc($urandom_range(0, N - 1), 7, 7);
    drive_cfg($urandom_range(0, N - 1), 3, 3, 3);
    step();
    idle_inputs();
    flush = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("reset_mid_wait");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    hold = 1'b0;
    step();
    flush = 1'b0;
    base = n_issues;
    repeat (10) step();
    check("no_issue_after_reset", n_issues, base);
    check("in_ready_after_reset", ifc.in_ready, 1);
  endtask

  // Monitor: compare every presented issue against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ifc.core_valid === 1'b1) begin
        mon_act = {ifc.core_channel, ifc.core_good, ifc.core_bad, ifc.core_good_thr,
                   ifc.core_bad_thr, ifc.core_duration, ifc.core_tick};
        n_issues++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          cur_ch = int'(ifc.core_channel);
          $display("FAIL unexpected_issue: got ch=%0d g=%0d tick=%0d, expected no issue",
                   mon_act.ch, mon_act.g, mon_act.tk);
        end else begin
          mon_exp = exp_q.pop_front();
          cur_ch = int'(mon_exp.ch);
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL issue: got ch=%0d g=%0d b=%0d gt=%0d bt=%0d d=%0d tick=%0d, expected ch=%0d g=%0d b=%0d gt=%0d bt=%0d d=%0d tick=%0d",
                     mon_act.ch, mon_act.g, mon_act.b, mon_act.gt, mon_act.bt, mon_act.d,
                     mon_act.tk, mon_exp.ch, mon_exp.g, mon_exp.b, mon_exp.gt, mon_exp.bt,
                     mon_exp.d, mon_exp.tk);
          end
        end
      end
    end
  end

  // Core responder: answers each issue after a random delay (or when released)
  initial begin
    int dly;
    bit rs, re;
    ifc.core_done = 1'b0; ifc.core_token_start = 1'b0; ifc.core_token_end = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && ifc.core_valid === 1'b1) begin
        dly = $urandom_range(0, 2);
        @(posedge clk);
        #1;
        while (!flush && (hold || dly > 0)) begin
          if (!hold) dly--;
          @(posedge clk);
          #1;
        end
        if (!flush) begin
          rs = se_mode ? se_start_fix : 1'($urandom_range(0, 1));
          re = se_mode ? se_end_fix : 1'($urandom_range(0, 1));
          ifc.core_done = 1'b1; ifc.core_token_start = rs; ifc.core_token_end = re;
          @(posedge clk);
          #1;
          ifc.core_done = 1'b0; ifc.core_token_start = 1'b0; ifc.core_token_end = 1'b0;
          if (re) act_m[cur_ch] = 1'b0;
          else if (rs) act_m[cur_ch] = 1'b1;
          check("active", ifc.active, act_m);
          check("busy_after_done", ifc.busy, 0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle_inputs();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    check("in_ready", ifc.in_ready, 1);
    check("no_spurious_valid", ifc.core_valid, 0);

    run_segment(2, 3, 0, 1'b0, 0, 0, 1'b0);
    se_mode = 1'b1;
    se_start_fix = 1'b1; se_end_fix = 1'b0; run_segment(3, 1, 0, 1'b0, 0, 0, 1'b0);
    se_start_fix = 1'b0; se_end_fix = 1'b1; run_segment(3, 1, 0, 1'b0, 0, 0, 1'b0);
    se_start_fix = 1'b1; se_end_fix = 1'b0; run_segment(3, 1, 0, 1'b0, 0, 0, 1'b0);
    se_start_fix = 1'b1; se_end_fix = 1'b1; run_segment(3, 1, 0, 1'b0, 0, 0, 1'b0);
    se_mode = 1'b0;
    run_segment(0, 2, 0, 1'b0, 2, 5, 1'b0);
    run_segment(1, 1, 1, 1'b0, 3, 4, 1'b0);
    run_segment(0, 5, 2, 1'b1, 0, 0, 1'b0);
    run_segment(2, 1, 0, 1'b0, 4, 3, 1'b1);
    for (int s = 0; s < 20; s++) begin
      run_segment($urandom_range(0, N - 1), $urandom_range(1, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1, $urandom_range(2, 8), 1'($urandom_range(0, 1)));
    end
    reset_mid_wait();
    for (int s = 0; s < 4; s++) begin
      run_segment($urandom_range(0, N - 1), $urandom_range(1, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1, $urandom_range(2, 8), 1'b0);
    end
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
